// File: rtl/uart_tx.sv
// 8N1-style UART transmitter: one frame per accepted send request, with
// started/done pulses that pace the upstream data sender.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send,
  output logic                 tx,
  output logic                 busy,
  output logic                 transmission_started,
  output logic                 transmission_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic [1:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 started_q, started_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // Pulses default low every cycle; only the transition that owns them raises them.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    started_d = 1'b0;
    done_d    = 1'b0;

    if (state_q == IDLE) begin
      if (send) begin
        shift_d   = data_in;
        state_d   = START;
        cnt_d     = '0;
        tx_d      = 1'b0;
        busy_d    = 1'b1;
        started_d = 1'b1;
      end else begin
        tx_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (bit_end) begin
        cnt_d = '0;
        case (state_q)
          START: begin
            state_d = DATA;
            idx_d   = '0;
            tx_d    = shift_q[0];
          end
          DATA: begin
            // The next bit is taken from shift_q[1] so it lands on tx together with the shift.
            if (idx_q < IDX_LAST) begin
              shift_d = shift_q >> 1;
              idx_d   = idx_q + 3'd1;
              tx_d    = shift_q[1];
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end
          STOP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      started_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      started_q <= started_d;
      done_q    <= done_d;
    end
  end

  assign tx                   = tx_q;
  assign busy                 = busy_q;
  assign transmission_started = started_q;
  assign transmission_done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a timeline model (cycles since acceptance) checked every
// cycle on two instances, plus directed frames with hand-derived bit values.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sendA = 1'b0;
  logic       sendB = 1'b0;
  logic [7:0] dataA = 8'h00;
  logic [4:0] dataB = 5'h00;
  logic       txA, busyA, startedA, doneA;
  logic       txB, busyB, startedB, doneB;

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dutA (
    .clk(clk), .rst(rst), .data_in(dataA), .send(sendA), .tx(txA), .busy(busyA),
    .transmission_started(startedA), .transmission_done(doneA)
  );

  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5)) dutB (
    .clk(clk), .rst(rst), .data_in(dataB), .send(sendB), .tx(txB), .busy(busyB),
    .transmission_started(startedB), .transmission_done(doneB)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;
  bit checkEn    = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model: each instance is either idle or t cycles past its accepting edge.
  int         mN[2] = '{4, 2};
  int         mD[2] = '{8, 5};
  bit         mActive[2];
  int         mT[2];
  logic [7:0] mByte[2];
  bit         mJustDone[2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mActive[i]   = 1'b0;
        mT[i]        = 0;
        mJustDone[i] = 1'b0;
      end else if (!mActive[i]) begin
        mJustDone[i] = 1'b0;
        if ((i == 0) ? sendA : sendB) begin
          mActive[i] = 1'b1;
          mT[i]      = 0;
          mByte[i]   = (i == 0) ? dataA : {3'b000, dataB};
        end
      end else begin
        mT[i]++;
        if (mT[i] == (mD[i] + 2) * mN[i]) begin
          mActive[i]   = 1'b0;
          mJustDone[i] = 1'b1;
        end
      end
    end
  end

  function automatic logic expTx(input int i);
    int t;
    if (!mActive[i]) return 1'b1;
    t = mT[i];
    if (t < mN[i]) return 1'b0;
    if (t < (mD[i] + 1) * mN[i]) return mByte[i][(t / mN[i]) - 1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("model_tx%0d", i),      (i == 0) ? txA : txB,           expTx(i));
        checkOutput($sformatf("model_busy%0d", i),    (i == 0) ? busyA : busyB,       mActive[i]);
        checkOutput($sformatf("model_started%0d", i), (i == 0) ? startedA : startedB, mActive[i] && mT[i] == 0);
        checkOutput($sformatf("model_done%0d", i),    (i == 0) ? doneA : doneB,       !mActive[i] && mJustDone[i]);
      end
    end
  end

  logic txLog[300];
  bit   stLog[300], dnLog[300], bzLog[300];

  task automatic recordAt(input int j, input int inst);
    txLog[j] = (inst == 0) ? txA : txB;
    stLog[j] = (inst == 0) ? startedA : startedB;
    dnLog[j] = (inst == 0) ? doneA : doneB;
    bzLog[j] = (inst == 0) ? busyA : busyB;
  endtask

  // Called at a negedge; sample j is taken at the negedge following edge E0+j.
  task automatic applyStimulus(input logic [7:0] b, input int cycles);
    sendA = 1'b1;
    dataA = b;
    @(negedge clk);
    sendA = 1'b0;
    recordAt(0, 0);
    for (int j = 1; j < cycles; j++) begin
      @(negedge clk);
      recordAt(j, 0);
    end
  endtask

  logic exp55[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic expA3[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic exp1B[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] expInteg[5] = '{8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

  initial begin
    int cnt, cnt2, run, nFrames, senderIdx;
    bit allSent;
    logic [7:0] rxByte;
    logic [39:0] word;

    $display("[TB] uart_tx bench starting");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_tx",      txA, 1'b1);
    checkOutput("reset_busy",    busyA, 1'b0);
    checkOutput("reset_started", startedA, 1'b0);
    checkOutput("reset_done",    doneA, 1'b0);
    checkOutput("reset_txB",     txB, 1'b1);
    rst = 1'b0;
    checkEn = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 0x55
    applyStimulus(8'h55, 42);
    for (int b = 0; b < 10; b++)
      checkOutput($sformatf("frame55_bit%0d", b), txLog[b * 4 + 2], exp55[b]);
    checkOutput("frame55_started0", stLog[0], 1'b1);
    checkOutput("frame55_started1", stLog[1], 1'b0);
    checkOutput("frame55_done39", dnLog[39], 1'b0);
    checkOutput("frame55_done40", dnLog[40], 1'b1);
    checkOutput("frame55_done41", dnLog[41], 1'b0);
    checkOutput("frame55_busy39", bzLog[39], 1'b1);
    checkOutput("frame55_busy40", bzLog[40], 1'b0);
    repeat (3) @(negedge clk);

    // Data stability: data_in and send disturbed mid-frame
    sendA = 1'b1;
    dataA = 8'hA3;
    @(negedge clk);
    sendA = 1'b0;
    recordAt(0, 0);
    for (int j = 1; j < 45; j++) begin
      @(negedge clk);
      if (j == 10) begin dataA = 8'hFF; sendA = 1'b1; end
      if (j == 14) sendA = 1'b0;
      recordAt(j, 0);
    end
    for (int b = 0; b < 8; b++)
      checkOutput($sformatf("stable_bit%0d", b), txLog[(b + 1) * 4 + 2], expA3[b]);
    cnt = 0; cnt2 = 0;
    for (int j = 0; j < 45; j++) begin cnt += int'(stLog[j]); cnt2 += int'(dnLog[j]); end
    checkOutput("stable_started_count", cnt, 1);
    checkOutput("stable_done_count", cnt2, 1);
    checkOutput("stable_idle_end", bzLog[44], 1'b0);
    repeat (2) @(negedge clk);

    // Back-to-back frames with send held high
    sendA = 1'b1;
    dataA = 8'h11;
    @(negedge clk);
    recordAt(0, 0);
    for (int j = 1; j < 86; j++) begin
      @(negedge clk);
      recordAt(j, 0);
      if (doneA) dataA = 8'h22;
      if (startedA) sendA = 1'b0;
    end
    run = 0;
    for (int j = 36; j < 60; j++) begin
      if (txLog[j] !== 1'b1) break;
      run++;
    end
    checkOutput("b2b_last_data_bit", txLog[35], 1'b0);
    checkOutput("b2b_stop_len", run, 5);
    rxByte = '0;
    for (int k = 0; k < 8; k++) rxByte[k] = txLog[41 + (k + 1) * 4 + 2];
    checkOutput("b2b_second_byte", rxByte, 8'h22);
    cnt = 0; cnt2 = 0;
    for (int j = 0; j < 86; j++) begin cnt += int'(stLog[j]); cnt2 += int'(dnLog[j]); end
    checkOutput("b2b_started_count", cnt, 2);
    checkOutput("b2b_done_count", cnt2, 2);
    repeat (2) @(negedge clk);

    // Reset during data bit 3 (samples 16..19)
    sendA = 1'b1;
    dataA = 8'h5A;
    @(negedge clk);
    sendA = 1'b0;
    repeat (17) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_tx", txA, 1'b1);
    checkOutput("midrst_busy", busyA, 1'b0);
    checkOutput("midrst_started", startedA, 1'b0);
    checkOutput("midrst_done", doneA, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (txA !== 1'b1) cnt++;
      if (doneA || startedA) cnt2++;
    end
    checkOutput("postrst_tx_low_cycles", cnt, 0);
    checkOutput("postrst_pulses", cnt2, 0);

    // Integration with a data sender: send tied to !busy
    word = 40'h1122334455;
    senderIdx = 0;
    allSent = 1'b0;
    for (int j = 0; j < 240; j++) begin
      if (doneA) begin
        senderIdx++;
        if (senderIdx == 5) allSent = 1'b1;
      end
      dataA = (senderIdx < 5) ? word[8 * senderIdx +: 8] : 8'h00;
      sendA = !busyA && !allSent;
      recordAt(j, 0);
      @(negedge clk);
    end
    sendA = 1'b0;
    nFrames = 0;
    for (int s = 0; s < 200; s++) begin
      if (stLog[s]) begin
        rxByte = '0;
        for (int k = 0; k < 8; k++) rxByte[k] = txLog[s + (k + 1) * 4 + 2];
        if (nFrames < 5) checkOutput($sformatf("integ_byte%0d", nFrames), rxByte, expInteg[nFrames]);
        nFrames++;
      end
    end
    checkOutput("integ_frames", nFrames, 5);
    cnt2 = 0;
    for (int j = 0; j < 240; j++) cnt2 += int'(dnLog[j]);
    checkOutput("integ_done_count", cnt2, 5);
    checkOutput("integ_all_sent", allSent, 1'b1);
    repeat (2) @(negedge clk);

    // Parameter corner: 2 clocks per bit, 5 data bits
    sendB = 1'b1;
    dataB = 5'h1B;
    @(negedge clk);
    sendB = 1'b0;
    recordAt(0, 1);
    for (int j = 1; j < 16; j++) begin
      @(negedge clk);
      recordAt(j, 1);
    end
    checkOutput("corner_start", txLog[1], 1'b0);
    for (int b = 0; b < 5; b++)
      checkOutput($sformatf("corner_bit%0d", b), txLog[(b + 1) * 2 + 1], exp1B[b]);
    checkOutput("corner_done13", dnLog[13], 1'b0);
    checkOutput("corner_done14", dnLog[14], 1'b1);
    checkOutput("corner_busy13", bzLog[13], 1'b1);
    checkOutput("corner_busy14", bzLog[14], 1'b0);
    repeat (2) @(negedge clk);

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter stage directly downstream of the data sender. It consumes one byte per request and drives the idle-high UART line as 8N1 (start, 8 data bits LSB first, stop). It returns the `transmission_started` and `transmission_done` pulses the data sender uses to latch its next byte and advance its byte index.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is ≥ 2. The counter is $clog2(CLKS_PER_BIT) bits wide.
- `DATA_BITS`, default 8: data bits per frame. Legal range is 5–8.

Ports:
- `clk`  in  1  system clock. Everything is registered on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `data_in`  in  DATA_BITS  byte to send. Sampled only on the edge that accepts `send`.
- `send`  in  1  level request. Honoured only in IDLE.
- `tx`  out  1  serial line, idle high. Registered.
- `busy`  out  1  high from the accepting edge until the edge that ends the stop bit.
- `transmission_started`  out  1  one-cycle pulse in the first cycle of the start bit.
- `transmission_done`  out  1  one-cycle pulse in the first cycle after the stop bit.

## Operation
- **States:** IDLE, START, DATA, STOP.
- **Internal registers:** shift register (DATA_BITS), baud counter, bit index (3 bits).
- **Reset (async):**
  - `tx`=1, `busy`=0, `transmission_started`=0, `transmission_done`=0.
  - state IDLE; counter and index = 0.
  - A reset mid-frame aborts the frame at once: `tx` returns high and no done pulse is produced.
- **IDLE, `send`=1 at an edge:**
  - latch `data_in` into the shift register;
  - state → START, counter=0;
  - `tx`←0, `busy`←1, `transmission_started`←1.
- **IDLE, `send`=0:** `tx` stays 1.
- **Bit timing in START, DATA, STOP:**
  - The counter increments every cycle.
  - When counter = CLKS_PER_BIT−1, the bit period ends: counter←0.
- **START end:** state → DATA, index=0, `tx`←shift[0].
- **DATA end:**
  - If index < DATA_BITS−1: shift right, index+1, `tx`←next bit.
  - Else: state → STOP, `tx`←1.
- **STOP end:** state → IDLE, `busy`←0, `transmission_done`←1.
- **Pulses:**
  - `transmission_started` and `transmission_done` are cleared on every edge where they are not being set. Each is exactly 1 cycle wide.
  - The two pulses never coincide.
- **Ignored inputs while busy:**
  - `send` while not IDLE is ignored. Requests are not queued.
  - Changes on `data_in` while busy have no effect on the frame.
- **Back-to-back:** `send` held high produces continuous frames. Each stop bit is CLKS_PER_BIT+1 cycles long, because of the one IDLE cycle where `send` is re-sampled.

## Timing
Edge numbering: E0 is the accepting edge; N = CLKS_PER_BIT.

- `tx` is low for cycles E0 … E0+N.
- Data bit k (k = 0 … DATA_BITS−1) is on `tx` from edge E0+(k+1)·N for N cycles.
- Stop bit starts at E0+(DATA_BITS+1)·N.
- `transmission_done` and `busy`=0 are set at E0+(DATA_BITS+2)·N. This is 10·N cycles after E0 for 8 data bits.
- `transmission_started` is high in the cycle E0 … E0+1.
- Earliest next accepting edge is E0+(DATA_BITS+2)·N+1.
- Latency from `send` sampled to `tx` falling: 1 edge, registered.
- Data sender coupling:
  - The data sender latches its word on `transmission_started`.
  - It advances its byte on `transmission_done`.
  - Its next byte must be on `data_in` at or before the next accepting edge; one cycle of slack exists.

## Test plan
- **Single frame.** CLKS_PER_BIT=4, `data_in`=0x55, `send` pulsed for 1 cycle.
  - `tx` per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1.
  - `transmission_started` high exactly 1 cycle after the accepting edge.
  - `transmission_done` high exactly 1 cycle, 40 cycles after the accepting edge; `busy` falls at the same edge.
- **Data stability.** Send 0xA3, then change `data_in` to 0xFF and pulse `send` mid-frame.
  - The line still carries bits 1,1,0,0,0,1,0,1.
  - No second frame starts and no extra started pulse appears.
- **Back-to-back.** Hold `send`=1 with `data_in` 0x11 then 0x22, switched on `transmission_done`.
  - Two frames; the stop bit between them is 5 cycles.
  - Second frame carries 0x22; two started and two done pulses.
- **Reset mid-frame.** Assert `rst` during data bit 3.
  - `tx`=1, `busy`=0 and both pulses 0 immediately, without waiting for a clock.
  - After release, `tx` stays idle high until the next `send`.
- **Integration with the data sender.** Word 0x1122334455, `send` tied to `!busy`.
  - Serial bytes appear in order 0x55, 0x44, 0x33, 0x22, 0x11.
  - `all_bytes_sent` asserts after the fifth `transmission_done`.
- **Parameter corner.** CLKS_PER_BIT=2, DATA_BITS=5, `data_in`=0x1B.
  - Bits 1,1,0,1,1, each 2 cycles.
  - `transmission_done` 14 cycles after the accepting edge.
